fetch_align: RTL and testbench

Instruction fetch stage sitting directly downstream of the prefetch FIFO and upstream of decode. Owns the architectural fetch PC, issues halfword-aligned requests to prefetch, classifies each returned window as compressed (16-bit) or full (32-bit), advances the PC by 2 or 4, and buffers fetched instructions in a 2-entry skid queue toward decode under a valid/ready handshake. Handles redirects from execute/CSR by flushing the queue and clearing prefetch.

---
 rtl/fetch_align.sv | 106 ++++++++++
 tb/tb_fetch_align.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/fetch_align.sv
// Fetch PC owner: issues halfword-aligned requests to prefetch, sizes each window
// as 16/32-bit and buffers fetched instructions in a small skid queue toward decode.
//   state | meaning
//   FLUSH | one idle cycle after reset/redirect, no request
//   RUN   | requesting while the skid queue has room
module fetch_align #(
  parameter int               XLEN       = 32,
  parameter logic [XLEN-1:0]  RESET_PC   = XLEN'(32'h8000_0000),
  parameter int               SKID_DEPTH = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  output logic            pref_req_o,
  output logic [XLEN-1:0] pref_pc_o,
  output logic            pref_misalign_o,
  output logic            pref_is_comp_o,
  output logic            pref_clear_o,
  input  logic            pref_ack_i,
  input  logic [31:0]     pref_instr_i,
  output logic            id_valid_o,
  input  logic            id_ready_i,
  output logic [31:0]     id_instr_o,
  output logic [XLEN-1:0] id_pc_o,
  output logic            id_is_comp_o
);

  localparam int PW = $clog2(SKID_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic {FLUSH, RUN} state_t;

  state_t          state, next_state;
  logic [XLEN-1:0] pc;
  logic [CW-1:0]   count;
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic            accept, dequeue;
  logic [31:0]     enq_instr;

  logic [31:0]     q_instr [SKID_DEPTH];
  logic [XLEN-1:0] q_pc    [SKID_DEPTH];
  logic            q_comp  [SKID_DEPTH];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= FLUSH;
    else        state <= next_state;
  end

  always_comb begin
    next_state   = state;
    pref_req_o   = 1'b0;
    pref_clear_o = redirect_i;
    if (redirect_i) begin
      next_state = FLUSH;
    end else if (state == FLUSH) begin
      next_state = RUN;
    end else begin
      pref_req_o = (count < CW'(SKID_DEPTH));
    end
  end

  assign pref_pc_o       = pc;
  assign pref_misalign_o = pc[1];
  assign pref_is_comp_o  = (pref_instr_i[1:0] != 2'b11);
  assign enq_instr       = pref_is_comp_o ? {16'h0, pref_instr_i[15:0]} : pref_instr_i;

  // pref_req_o already excludes redirect cycles, so a coincident ack is dropped here
  assign accept  = pref_req_o && pref_ack_i;
  assign id_valid_o = (count != '0);
  assign dequeue = id_valid_o && id_ready_i;

  assign id_instr_o   = q_instr[rd_ptr];
  assign id_pc_o      = q_pc[rd_ptr];
  assign id_is_comp_o = q_comp[rd_ptr];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc     <= RESET_PC;
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < SKID_DEPTH; i++) begin
        q_instr[i] <= 32'h0000_0013;
        q_pc[i]    <= '0;
        q_comp[i]  <= 1'b0;
      end
    end else if (redirect_i) begin
      pc     <= redirect_pc_i & ~XLEN'(1);
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (accept) begin
        q_instr[wr_ptr] <= enq_instr;
        q_pc[wr_ptr]    <= pc;
        q_comp[wr_ptr]  <= pref_is_comp_o;
        wr_ptr          <= wr_ptr + PW'(1);
        pc              <= pc + (pref_is_comp_o ? XLEN'(2) : XLEN'(4));
      end
      if (dequeue) rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(accept) - CW'(dequeue);
    end
  end

endmodule

// File: tb/tb_fetch_align.sv
// Directed bench for fetch_align: reset values, streaming, mixed sizes, backpressure,
// redirect with full queue, PC wrap and mid-stream reset.
module tb_fetch_align;

  logic        clk = 1'b0;
  logic        reset;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        pref_req_o;
  logic [31:0] pref_pc_o;
  logic        pref_misalign_o;
  logic        pref_is_comp_o;
  logic        pref_clear_o;
  logic        pref_ack_i;
  logic [31:0] pref_instr_i;
  logic        id_valid_o;
  logic        id_ready_i;
  logic [31:0] id_instr_o;
  logic [31:0] id_pc_o;
  logic        id_is_comp_o;

  int n_cmp = 0;
  int n_err = 0;
  int accepts;

  always #5 clk = ~clk;

  fetch_align dut (
    .clk(clk), .reset(reset),
    .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
    .pref_req_o(pref_req_o), .pref_pc_o(pref_pc_o),
    .pref_misalign_o(pref_misalign_o), .pref_is_comp_o(pref_is_comp_o),
    .pref_clear_o(pref_clear_o), .pref_ack_i(pref_ack_i), .pref_instr_i(pref_instr_i),
    .id_valid_o(id_valid_o), .id_ready_i(id_ready_i), .id_instr_o(id_instr_o),
    .id_pc_o(id_pc_o), .id_is_comp_o(id_is_comp_o)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0; redirect_i = 1'b0; redirect_pc_i = '0;
    pref_ack_i = 1'b0; pref_instr_i = '0; id_ready_i = 1'b1;
    #12;
    check("rst_req",      32'(pref_req_o),      32'd0);
    check("rst_pc",       pref_pc_o,            32'h8000_0000);
    check("rst_misalign", 32'(pref_misalign_o), 32'd0);
    check("rst_clear",    32'(pref_clear_o),    32'd0);
    check("rst_valid",    32'(id_valid_o),      32'd0);
    check("rst_instr",    id_instr_o,           32'h0000_0013);
    check("rst_idpc",     id_pc_o,              32'd0);
    check("rst_comp",     32'(id_is_comp_o),    32'd0);

    // streaming full instructions from RESET_PC
    pref_ack_i = 1'b1; pref_instr_i = 32'h0000_0093;
    @(negedge clk); reset = 1'b1;
    tick(); #1;
    check("s1_req",   32'(pref_req_o), 32'd1);
    check("s1_pc",    pref_pc_o,       32'h8000_0000);
    check("s1_comp",  32'(pref_is_comp_o), 32'd0);
    check("s1_valid", 32'(id_valid_o), 32'd0);
    tick(); #1;
    check("s2_valid", 32'(id_valid_o), 32'd1);
    check("s2_idpc",  id_pc_o,         32'h8000_0000);
    check("s2_pc",    pref_pc_o,       32'h8000_0004);
    check("s2_idcmp", 32'(id_is_comp_o), 32'd0);
    tick(); #1;
    check("s3_idpc",  id_pc_o,   32'h8000_0004);
    check("s3_pc",    pref_pc_o, 32'h8000_0008);
    tick(); #1;
    check("s4_idpc",  id_pc_o,   32'h8000_0008);
    check("s4_instr", id_instr_o, 32'h0000_0093);

    // mixed compressed/full stream from 0x100
    redirect_i = 1'b1; redirect_pc_i = 32'h100; #1;
    check("m_clear", 32'(pref_clear_o), 32'd1);
    check("m_req0",  32'(pref_req_o),   32'd0);
    tick(); redirect_i = 1'b0; #1;
    check("m_clear2", 32'(pref_clear_o), 32'd0);
    check("m_flreq",  32'(pref_req_o),   32'd0);
    check("m_flval",  32'(id_valid_o),   32'd0);
    tick(); pref_instr_i = 32'h0000_4501; #1;
    check("m1_req",  32'(pref_req_o),      32'd1);
    check("m1_pc",   pref_pc_o,            32'h100);
    check("m1_mis",  32'(pref_misalign_o), 32'd0);
    check("m1_comp", 32'(pref_is_comp_o),  32'd1);
    tick(); pref_instr_i = 32'h00A0_0513; #1;
    check("m2_idins", id_instr_o,          32'h0000_4501);
    check("m2_idpc",  id_pc_o,             32'h100);
    check("m2_idcmp", 32'(id_is_comp_o),   32'd1);
    check("m2_pc",    pref_pc_o,           32'h102);
    check("m2_mis",   32'(pref_misalign_o), 32'd1);
    check("m2_comp",  32'(pref_is_comp_o), 32'd0);
    tick(); pref_instr_i = 32'h0000_0505; #1;
    check("m3_idins", id_instr_o,          32'h00A0_0513);
    check("m3_idpc",  id_pc_o,             32'h102);
    check("m3_pc",    pref_pc_o,           32'h106);
    check("m3_mis",   32'(pref_misalign_o), 32'd1);
    tick(); pref_ack_i = 1'b0; #1;
    check("m4_idins", id_instr_o,        32'h0000_0505);
    check("m4_idpc",  id_pc_o,           32'h106);
    check("m4_idcmp", 32'(id_is_comp_o), 32'd1);
    check("m4_pc",    pref_pc_o,         32'h108);

    // backpressure: decode stalled for 5 cycles
    redirect_i = 1'b1; redirect_pc_i = 32'h200;
    tick(); redirect_i = 1'b0;
    tick();
    id_ready_i = 1'b0; pref_ack_i = 1'b1; pref_instr_i = 32'h0000_0093;
    accepts = 0;
    for (int i = 0; i < 5; i++) begin
      #1;
      if (pref_req_o && pref_ack_i) accepts++;
      tick();
    end
    #1;
    check("bp_accepts", 32'(accepts),    32'd2);
    check("bp_req",     32'(pref_req_o), 32'd0);
    check("bp_pc",      pref_pc_o,       32'h208);
    check("bp_idpc",    id_pc_o,         32'h200);
    id_ready_i = 1'b1; #1;
    check("bp_req_full", 32'(pref_req_o), 32'd0);
    tick(); #1;
    check("bp_drain1", id_pc_o,         32'h204);
    check("bp_resume", 32'(pref_req_o), 32'd1);
    check("bp_pc2",    pref_pc_o,       32'h208);
    tick(); #1;
    check("bp_drain2", id_pc_o,   32'h208);
    check("bp_pc3",    pref_pc_o, 32'h20C);

    // redirect with a full queue and a coincident ack
    id_ready_i = 1'b0;
    tick(); #1;
    check("rd_full_req", 32'(pref_req_o), 32'd0);
    redirect_i = 1'b1; redirect_pc_i = 32'h2003; #1;
    check("rd_clear", 32'(pref_clear_o), 32'd1);
    check("rd_req",   32'(pref_req_o),   32'd0);
    tick(); redirect_i = 1'b0; id_ready_i = 1'b1; #1;
    check("rd_valid",  32'(id_valid_o),   32'd0);
    check("rd_clear2", 32'(pref_clear_o), 32'd0);
    check("rd_flreq",  32'(pref_req_o),   32'd0);
    tick(); #1;
    check("rd_req2", 32'(pref_req_o),      32'd1);
    check("rd_pc",   pref_pc_o,            32'h2002);
    check("rd_mis",  32'(pref_misalign_o), 32'd1);
    check("rd_val2", 32'(id_valid_o),      32'd0);

    // PC wrap-around
    redirect_i = 1'b1; redirect_pc_i = 32'hFFFF_FFFC;
    tick(); redirect_i = 1'b0;
    tick(); #1;
    check("wr_pc0", pref_pc_o, 32'hFFFF_FFFC);
    tick(); #1;
    check("wr_pc1",  pref_pc_o, 32'h0000_0000);
    check("wr_idpc", id_pc_o,   32'hFFFF_FFFC);

    // asynchronous reset with valid entries
    id_ready_i = 1'b0;
    tick(); #1;
    check("ar_valid_pre", 32'(id_valid_o), 32'd1);
    reset = 1'b0; #1;
    check("ar_valid", 32'(id_valid_o), 32'd0);
    check("ar_req",   32'(pref_req_o), 32'd0);
    check("ar_pc",    pref_pc_o,       32'h8000_0000);
    @(negedge clk); reset = 1'b1; id_ready_i = 1'b1;
    tick(); #1;
    check("ar_restart_req", 32'(pref_req_o), 32'd1);
    check("ar_restart_pc",  pref_pc_o,       32'h8000_0000);
    check("ar_restart_val", 32'(id_valid_o), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
